// File: rtl/unified_mem_arbiter.sv
// Arbitrates one single-port memory between the fetch port and the data port, with a timeout abort.
// Define ARB_ROUND_ROBIN_EN to alternate the collision winner instead of always favouring data.
module unified_mem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  output logic              if_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic              d_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              bus_err
);
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY_IF = 2'd1, BUSY_D = 2'd2} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              if_valid_q, if_valid_d;
  logic              d_valid_q, d_valid_d;
  logic              bus_err_q, bus_err_d;
  logic              eff_if, eff_d, pick_d;

  // The port that just completed is masked for one cycle so a held request is not re-served.
  assign eff_if = if_req & ~if_valid_q;
  assign eff_d  = d_req & ~d_valid_q;

`ifdef ARB_ROUND_ROBIN_EN
  logic rr_ptr_q, rr_ptr_d;  // 1: data wins the next collision
  assign pick_d = eff_d & (~eff_if | rr_ptr_q);
`else
  assign pick_d = eff_d;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_valid_d  = 1'b0;
    d_valid_d   = 1'b0;
    bus_err_d   = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    rr_ptr_d    = rr_ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (eff_if | eff_d) begin
          mem_req_d = 1'b1;
          cnt_d     = '0;
          if (pick_d) begin
            mem_we_d    = d_we;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
            state_d     = BUSY_D;
`ifdef ARB_ROUND_ROBIN_EN
            rr_ptr_d    = 1'b0;
`endif
          end else begin
            mem_we_d    = 1'b0;
            mem_addr_d  = if_addr;
            state_d     = BUSY_IF;
`ifdef ARB_ROUND_ROBIN_EN
            rr_ptr_d    = 1'b1;
`endif
          end
        end
      end
      BUSY_IF, BUSY_D: begin
        if (mem_ready) begin
          mem_req_d = 1'b0;
          state_d   = IDLE;
          if (state_q == BUSY_IF) begin
            if_valid_d = 1'b1;
            if_rdata_d = mem_rdata;
          end else begin
            d_valid_d = 1'b1;
            if (!mem_we_q) d_rdata_d = mem_rdata;
          end
        end else if (cnt_q == CNT_W'(TIMEOUT_CYC)) begin
          mem_req_d = 1'b0;
          bus_err_d = 1'b1;
          state_d   = IDLE;
          if (state_q == BUSY_IF) begin
            if_valid_d = 1'b1;
            if_rdata_d = '0;
          end else begin
            d_valid_d = 1'b1;
            d_rdata_d = '0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_valid_q  <= 1'b0;
      d_valid_q   <= 1'b0;
      bus_err_q   <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      rr_ptr_q    <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_valid_q  <= if_valid_d;
      d_valid_q   <= d_valid_d;
      bus_err_q   <= bus_err_d;
`ifdef ARB_ROUND_ROBIN_EN
      rr_ptr_q    <= rr_ptr_d;
`endif
    end
  end

  assign if_rdata  = if_rdata_q;
  assign if_valid  = if_valid_q;
  assign if_stall  = if_req & ~if_valid_q;
  assign d_rdata   = d_rdata_q;
  assign d_valid   = d_valid_q;
  assign d_stall   = d_req & ~d_valid_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign bus_err   = bus_err_q;
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_unified_mem_arbiter;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, d_req, d_we, mem_ready;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic        if_valid, if_stall, d_valid, d_stall, mem_req, mem_we, bus_err;

  unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid), .if_stall(if_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_valid(d_valid), .d_stall(d_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: one access in flight at a time; it ends on the first ready cycle or is
  // aborted once it has held the bus TO+1 cycles without an acknowledge.
  bit          m_busy, m_is_d, m_we, m_turn_d;
  bit          m_if_valid, m_d_valid, m_err;
  int          m_age;
  logic [31:0] m_addr, m_wdata, m_if_rdata, m_d_rdata;
  bit          w_if, w_d, take_d, nv_if, nv_d, nerr;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_busy = 0; m_is_d = 0; m_we = 0; m_turn_d = 1; m_age = 0;
      m_if_valid = 0; m_d_valid = 0; m_err = 0;
      m_addr = '0; m_wdata = '0; m_if_rdata = '0; m_d_rdata = '0;
    end else begin
      nv_if = 0; nv_d = 0; nerr = 0;
      if (!m_busy) begin
        w_if = if_req && !m_if_valid;
        w_d  = d_req && !m_d_valid;
        if (w_if || w_d) begin
`ifdef ARB_ROUND_ROBIN_EN
          take_d = w_d && (!w_if || m_turn_d);
`else
          take_d = w_d;
`endif
          m_turn_d = !take_d;
          m_busy = 1; m_is_d = take_d; m_age = 1;
          m_we   = take_d ? d_we : 1'b0;
          m_addr = take_d ? d_addr : if_addr;
          if (take_d) m_wdata = d_wdata;
        end
      end else if (mem_ready) begin
        m_busy = 0;
        if (m_is_d) begin
          nv_d = 1;
          if (!m_we) m_d_rdata = mem_rdata;
        end else begin
          nv_if = 1;
          m_if_rdata = mem_rdata;
        end
      end else if (m_age == TO + 1) begin
        m_busy = 0; nerr = 1;
        if (m_is_d) begin nv_d = 1; m_d_rdata = '0; end
        else begin nv_if = 1; m_if_rdata = '0; end
      end else begin
        m_age++;
      end
      m_if_valid = nv_if; m_d_valid = nv_d; m_err = nerr;
    end
  end

  always @(negedge clk) begin
    chk1("if_valid", if_valid, m_if_valid);
    chk1("d_valid", d_valid, m_d_valid);
    chk1("bus_err", bus_err, m_err);
    chk1("mem_req", mem_req, m_busy);
    chk32("if_rdata", if_rdata, m_if_rdata);
    chk32("d_rdata", d_rdata, m_d_rdata);
    chk1("if_stall", if_stall, if_req & ~m_if_valid);
    chk1("d_stall", d_stall, d_req & ~m_d_valid);
    if (m_busy) begin
      chk32("mem_addr", mem_addr, m_addr);
      chk1("mem_we", mem_we, m_we);
      if (m_we) chk32("mem_wdata", mem_wdata, m_wdata);
    end
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic lone_fetch(input logic [31:0] a, input logic [31:0] dat);
    if_req = 1; if_addr = a; mem_ready = 0;
    #1 chk1("lf_stall_n", if_stall, 1'b1);
    cyc();
    chk1("lf_mem_req", mem_req, 1'b1);
    chk32("lf_mem_addr", mem_addr, a);
    chk1("lf_stall_n1", if_stall, 1'b1);
    mem_ready = 1; mem_rdata = dat;
    cyc();
    chk1("lf_valid", if_valid, 1'b1);
    chk32("lf_rdata", if_rdata, dat);
    if_req = 0; mem_ready = 0;
    cyc();
    chk1("lf_valid_once", if_valid, 1'b0);
    chk1("lf_req_done", mem_req, 1'b0);
  endtask

  bit rr_first_if;

  initial begin
`ifdef ARB_ROUND_ROBIN_EN
    rr_first_if = 1;
`else
    rr_first_if = 0;
`endif
    reset = 0; if_req = 0; d_req = 0; d_we = 0; mem_ready = 0;
    if_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
    repeat (3) @(negedge clk);
    #1;
    chk1("rst_mem_req", mem_req, 1'b0);
    chk1("rst_if_valid", if_valid, 1'b0);
    chk1("rst_bus_err", bus_err, 1'b0);
    chk32("rst_mem_addr", mem_addr, 32'h0);
    chk32("rst_d_rdata", d_rdata, 32'h0);
    reset = 1;
    cyc();

    lone_fetch(32'h40, 32'h8C010004);

    // held request one cycle past if_valid is not re-served
    if_req = 1; if_addr = 32'h48;
    cyc(); mem_ready = 1; mem_rdata = 32'h11112222;
    cyc(); chk1("mask_valid", if_valid, 1'b1); mem_ready = 0;
    cyc(); chk1("mask_no_req", mem_req, 1'b0); if_req = 0;
    cyc(); chk1("mask_no_req2", mem_req, 1'b0);

    // collision A: data first, fetch granted in the d_valid cycle
    if_req = 1; if_addr = 32'h44; d_req = 1; d_we = 0; d_addr = 32'h100;
    cyc();
    chk32("colA_addr1", mem_addr, 32'h100);
    chk1("colA_if_stall", if_stall, 1'b1);
    mem_ready = 1; mem_rdata = 32'h1234;
    cyc();
    chk1("colA_d_valid", d_valid, 1'b1);
    chk32("colA_d_rdata", d_rdata, 32'h1234);
    chk1("colA_if_stall2", if_stall, 1'b1);
    d_req = 0; mem_ready = 0;
    cyc();
    chk1("colA_req2", mem_req, 1'b1);
    chk32("colA_addr2", mem_addr, 32'h44);
    mem_ready = 1; mem_rdata = 32'h8C010008;
    cyc();
    chk1("colA_if_valid", if_valid, 1'b1);
    chk32("colA_if_rdata", if_rdata, 32'h8C010008);
    if_req = 0; mem_ready = 0;
    cyc();

    // collision B: data wins again; fetch withdraws so the pointer is left on fetch
    if_req = 1; d_req = 1;
    cyc(); chk32("colB_addr", mem_addr, 32'h100); mem_ready = 1; mem_rdata = 32'h1234;
    cyc(); chk1("colB_d_valid", d_valid, 1'b1); if_req = 0; d_req = 0; mem_ready = 0;
    cyc(); chk1("colB_idle", mem_req, 1'b0);

    // collision C: round-robin hands this one to fetch
    if_req = 1; d_req = 1;
    cyc();
    chk32("colC_first", mem_addr, rr_first_if ? 32'h44 : 32'h100);
    mem_ready = 1; mem_rdata = rr_first_if ? 32'h8C01000C : 32'h1234;
    cyc();
    chk1("colC_first_valid", rr_first_if ? if_valid : d_valid, 1'b1);
    if (rr_first_if) if_req = 0; else d_req = 0;
    mem_ready = 0;
    cyc();
    chk32("colC_second", mem_addr, rr_first_if ? 32'h100 : 32'h44);
    mem_ready = 1; mem_rdata = rr_first_if ? 32'h1234 : 32'h8C01000C;
    cyc();
    chk1("colC_second_valid", rr_first_if ? d_valid : if_valid, 1'b1);
    if_req = 0; d_req = 0; mem_ready = 0;
    cyc();

    // store with 3 wait cycles; write data change while busy must be ignored
    d_req = 1; d_we = 1; d_addr = 32'h200; d_wdata = 32'hCAFEF00D;
    for (int k = 1; k <= 4; k++) begin
      cyc();
      chk1("st_req", mem_req, 1'b1);
      chk1("st_we", mem_we, 1'b1);
      chk32("st_wdata", mem_wdata, 32'hCAFEF00D);
      d_wdata = 32'hDEADBEEF;
      mem_ready = (k == 4); mem_rdata = 32'h5555AAAA;
    end
    cyc();
    chk1("st_valid", d_valid, 1'b1);
    chk32("st_rdata_held", d_rdata, 32'h1234);
    d_req = 0; d_we = 0; mem_ready = 0;
    cyc();

    // timeout abort on a fetch
    if_req = 1; if_addr = 32'h80;
    for (int k = 1; k <= TO + 1; k++) begin
      cyc();
      chk1("to_req", mem_req, 1'b1);
      chk1("to_no_err", bus_err, 1'b0);
    end
    cyc();
    chk1("to_req_off", mem_req, 1'b0);
    chk1("to_err", bus_err, 1'b1);
    chk1("to_valid", if_valid, 1'b1);
    chk32("to_rdata", if_rdata, 32'h0);
    if_req = 0;
    cyc();
    chk1("to_err_once", bus_err, 1'b0);
    chk1("to_idle", mem_req, 1'b0);

    // reset in the middle of a data access
    d_req = 1; d_we = 0; d_addr = 32'h300;
    cyc();
    chk1("rm_busy", mem_req, 1'b1);
    #1 reset = 0;
    #1;
    chk1("rm_req_async", mem_req, 1'b0);
    chk32("rm_addr", mem_addr, 32'h0);
    chk32("rm_if_rdata", if_rdata, 32'h0);
    chk32("rm_d_rdata", d_rdata, 32'h0);
    d_req = 0;
    cyc(); cyc();
    reset = 1;
    cyc();
    chk1("rm_no_valid", d_valid, 1'b0);
    chk1("rm_no_err", bus_err, 1'b0);
    lone_fetch(32'h40, 32'h8C010004);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      if (!if_req || if_valid) begin
        if_req = ($urandom_range(0, 2) != 0); if_addr = $urandom;
      end else if ($urandom_range(0, 3) == 0) begin
        if_addr = $urandom;
      end
      if (!d_req || d_valid) begin
        d_req = ($urandom_range(0, 2) != 0); d_we = $urandom_range(0, 1) == 1;
        d_addr = $urandom; d_wdata = $urandom;
      end else if ($urandom_range(0, 3) == 0) begin
        d_addr = $urandom; d_wdata = $urandom; d_we = $urandom_range(0, 1) == 1;
      end
      mem_ready = ($urandom_range(0, 9) < 4);
      mem_rdata = $urandom;
      cyc();
    end
    if_req = 0; d_req = 0; mem_ready = 0;
    repeat (TO + 4) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
